// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: DW-bit dividend by VW-bit divisor,
// one quotient bit per clock, with a start/busy/done handshake.
//
// state  | meaning
// IDLE   | waiting for start; result outputs hold last completion
// CALC   | one restoring step per edge, count runs DW down to terminal 1
// DONE   | one-cycle done pulse; results were loaded on the entry edge
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = $clog2(DW + 1);

    logic [1:0]    state;
    logic [CW-1:0] count;
    // Dividend bits shift out of the top while quotient bits shift in at the
    // bottom, so after DW steps this register holds the quotient.
    logic [DW-1:0] dvd_q;
    logic [VW-1:0] dsr_q;
    // Partial remainder is always < divisor between steps, so VW bits suffice;
    // the extra bit only exists inside the combinational step.
    logic [VW-1:0] rem_q;

    logic [VW:0]   r_shift;
    logic          fits;
    logic [VW-1:0] rem_next;
    logic [DW-1:0] dvd_next;
    logic          last_step;

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    always_comb begin
        r_shift   = {rem_q, dvd_q[DW-1]};
        fits      = (r_shift >= {1'b0, dsr_q});
        // Result of a successful subtract is < divisor, so the low VW bits
        // of the modular difference are exact.
        rem_next  = fits ? (r_shift[VW-1:0] - dsr_q) : r_shift[VW-1:0];
        dvd_next  = {dvd_q[DW-2:0], fits};
        last_step = (count == CW'(1));
    end

    // Sequencer, datapath registers and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            dvd_q <= dividend;
                            dsr_q <= divisor;
                            rem_q <= '0;
                            count <= CW'(DW);
                            state <= S_CALC;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend[VW-1:0];
                            div_by_zero <= 1'b1;
                            state       <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    dvd_q <= dvd_next;
                    rem_q <= rem_next;
                    count <= count - CW'(1);
                    if (last_step) begin
                        quotient    <= dvd_next;
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode directly from the registered state.
    always_comb begin
        busy = (state == S_CALC);
        done = (state == S_DONE);
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (DW=8, VW=4): directed table, corner
// sequences, exhaustive nonzero sweep and random ops against a plain
// arithmetic reference.
module tb_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int npass  = 0;
    int ntotal = 0;

    seq_divider #(.DW(8), .VW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: plain arithmetic plus the divide-by-zero rules.
    task automatic model(input logic [7:0] a, input logic [3:0] b,
                         output logic [7:0] q, output logic [3:0] r, output logic z);
        logic [7:0] aa;
        aa = a;
        if (b == 4'd0) begin
            q = 8'hFF;
            r = aa[3:0];
            z = 1'b1;
        end else begin
            q = 8'(a / b);
            r = 4'(a % b);
            z = 1'b0;
        end
    endtask

    // Issue one op and wait (bounded) for done; lat counts negedges after the start edge.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                          output logic [7:0] q, output logic [3:0] r, output logic z,
                          output int lat, output logic bsy1);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat  = 0;
        bsy1 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) bsy1 = busy;
            if (done) begin
                lat = k;
                break;
            end
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
    endtask

    initial begin
        logic [7:0] gq, eq;
        logic [3:0] gr, er;
        logic       gz, ez, gb;
        int         lat;
        int         ndone;
        logic [7:0] a;
        logic [3:0] b;

        vecs[0] = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4,  z: 1'b0};
        vecs[1] = '{a: 8'd255, b: 4'd15, q: 8'd17,  r: 4'd0,  z: 1'b0};
        vecs[2] = '{a: 8'd5,   b: 4'd9,  q: 8'd0,   r: 4'd5,  z: 1'b0};
        vecs[3] = '{a: 8'd0,   b: 4'd1,  q: 8'd0,   r: 4'd0,  z: 1'b0};
        vecs[4] = '{a: 8'hA7,  b: 4'd0,  q: 8'hFF,  r: 4'h7,  z: 1'b1};
        vecs[5] = '{a: 8'd100, b: 4'd10, q: 8'd10,  r: 4'd0,  z: 1'b0};
        vecs[6] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0,  z: 1'b0};
        vecs[7] = '{a: 8'd1,   b: 4'd15, q: 8'd0,   r: 4'd1,  z: 1'b0};
        vecs[8] = '{a: 8'd0,   b: 4'd0,  q: 8'hFF,  r: 4'd0,  z: 1'b1};
        vecs[9] = '{a: 8'd255, b: 4'd0,  q: 8'hFF,  r: 4'hF,  z: 1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_q", 32'(quotient), 0);
        check("rst_r", 32'(remainder), 0);
        check("rst_z", 32'(div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy || done) ndone++;
        end
        check("idle_quiet", 32'(ndone), 0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, gq, gr, gz, lat, gb);
            check($sformatf("tbl%0d_lat", i), 32'(lat), (vecs[i].b == 0) ? 1 : 9);
            check($sformatf("tbl%0d_busy1", i), 32'(gb), (vecs[i].b == 0) ? 0 : 1);
            check($sformatf("tbl%0d_q", i), 32'(gq), 32'(vecs[i].q));
            check($sformatf("tbl%0d_r", i), 32'(gr), 32'(vecs[i].r));
            check($sformatf("tbl%0d_z", i), 32'(gz), 32'(vecs[i].z));
            @(negedge clk);
            check($sformatf("tbl%0d_pulse", i), 32'(done), 0);
            check($sformatf("tbl%0d_hold", i), 32'(quotient), 32'(vecs[i].q));
        end

        // Extra starts while busy/done, operands changed mid-run
        @(negedge clk);
        dividend = 8'd50;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dividend = 8'd77;
        divisor  = 4'd2;
        ndone = 0;
        gq = '0;
        gr = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                gq = quotient;
                gr = remainder;
            end
            if (c == 3 || c == 8 || c == 9) begin
                dividend = 8'd99;
                divisor  = 4'd9;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("busy_start_ndone", 32'(ndone), 1);
        check("busy_start_q", 32'(gq), 16);
        check("busy_start_r", 32'(gr), 2);

        // Reset mid-operation
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_q", 32'(quotient), 0);
        check("arst_r", 32'(remainder), 0);
        check("arst_z", 32'(div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("arst_no_done", 32'(ndone), 0);
        run_op(8'd200, 4'd7, gq, gr, gz, lat, gb);
        check("post_rst_q", 32'(gq), 28);
        check("post_rst_r", 32'(gr), 4);
        check("post_rst_lat", 32'(lat), 9);

        // Exhaustive nonzero sweep
        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 1; bi < 16; bi++) begin
                a = 8'(ai);
                b = 4'(bi);
                run_op(a, b, gq, gr, gz, lat, gb);
                model(a, b, eq, er, ez);
                check("sweep_q", 32'(gq), 32'(eq));
                check("sweep_r", 32'(gr), 32'(er));
                check("sweep_ident", 32'(gq) * 32'(b) + 32'(gr), 32'(a));
            end
        end

        // Random ops, divisor zero included
        for (int n = 0; n < 300; n++) begin
            a = 8'($urandom_range(0, 255));
            b = 4'($urandom_range(0, 15));
            run_op(a, b, gq, gr, gz, lat, gb);
            model(a, b, eq, er, ez);
            check("rnd_q", 32'(gq), 32'(eq));
            check("rnd_r", 32'(gr), 32'(er));
            check("rnd_z", 32'(gz), 32'(ez));
            check("rnd_lat", 32'(lat), (b == 0) ? 1 : 9);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
